// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - control/status bundle for scan_sequencer; Mask exists only when SCAN_MASK_EN is defined
interface scan_sequencer_if #(
   parameter int DWELL_W = 8
);
   logic               Start;
   logic               Stop;
   logic [DWELL_W-1:0] Dwell;
`ifdef SCAN_MASK_EN
   logic [7:0]         Mask;
`endif
   logic [2:0]         X;
   logic               En;
   logic               Busy;
   logic               Wrap;

`ifdef SCAN_MASK_EN
   modport master (output Start, Stop, Dwell, Mask, input X, En, Busy, Wrap);
   modport slave  (input Start, Stop, Dwell, Mask, output X, En, Busy, Wrap);
`else
   modport master (output Start, Stop, Dwell, input X, En, Busy, Wrap);
   modport slave  (input Start, Stop, Dwell, output X, En, Busy, Wrap);
`endif
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 3-to-8 decoder scan sequencer (IDLE/DWELL/BLANK); optional channel skipping under SCAN_MASK_EN
module scan_sequencer #(
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = 2
) (
   input  logic            Clk,
   input  logic            Rst_n,
   scan_sequencer_if.slave bus
);

   // Fewer than two blank cycles would leave no room to move X away from both En edges.
   localparam int BLANK_EFF = (BLANK_CYC < 2) ? 2 : BLANK_CYC;
   localparam int BCNT_W    = $clog2(BLANK_EFF + 1);
   localparam int CNT_W     = (DWELL_W > BCNT_W) ? DWELL_W : BCNT_W;
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t           state_q, state_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic [2:0]       x_q, x_nx;
   logic             en_q, busy_q, wrap_q, wrap_nx;
   logic             wrap_pend_q, wrap_pend_nx;
   logic             abort_q, abort_nx;
   logic [CNT_W-1:0] dwell_load;
   logic             mask_all;
   logic [2:0]       first_ch;
   logic [2:0]       next_ch;

`ifdef SCAN_MASK_EN
   function automatic logic [2:0] lowest_open(input logic [7:0] m);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Searching downward lets the smallest forward offset win; if nothing else is open, stay put.
   function automatic logic [2:0] next_open(input logic [2:0] cur, input logic [7:0] m);
      logic [2:0] r;
      logic [2:0] idx;
      r = cur;
      for (int i = 7; i >= 1; i--) begin
         idx = cur + 3'(i);
         if (!m[idx]) r = idx;
      end
      return r;
   endfunction

   assign mask_all = &bus.Mask;
   assign first_ch = lowest_open(bus.Mask);
   assign next_ch  = next_open(x_q, bus.Mask);
`else
   assign mask_all = 1'b0;
   assign first_ch = 3'd0;
   assign next_ch  = x_q + 3'd1;
`endif

   // A zero dwell still gives one En-high cycle.
   assign dwell_load = (bus.Dwell == '0) ? '0 : (CNT_W'(bus.Dwell) - CNT_ONE);

   // Next-state, counter, channel and wrap decisions.
   always_comb begin
      state_nx     = state_q;
      cnt_nx       = cnt_q;
      x_nx         = x_q;
      wrap_nx      = 1'b0;
      wrap_pend_nx = wrap_pend_q;
      abort_nx     = abort_q;
      case (state_q)
         IDLE: begin
            abort_nx = 1'b0;
            if (bus.Start && !bus.Stop && !mask_all) begin
               state_nx = DWELL;
               cnt_nx   = dwell_load;
               x_nx     = first_ch;
            end
         end
         DWELL: begin
            if (bus.Stop) begin
               state_nx = IDLE;
            end else if (cnt_q == '0) begin
               state_nx = BLANK;
               cnt_nx   = BLANK_LOAD;
            end else begin
               cnt_nx = cnt_q - CNT_ONE;
            end
         end
         BLANK: begin
            if (bus.Stop) begin
               state_nx = IDLE;
            end else begin
               // X moves only at the end of the first blank cycle, clear of both En edges.
               if (cnt_q == BLANK_LOAD) begin
                  if (mask_all) begin
                     abort_nx = 1'b1;
                  end else begin
                     x_nx         = next_ch;
                     wrap_pend_nx = (next_ch <= x_q);
                  end
               end
               if (cnt_q == '0) begin
                  if (abort_q) begin
                     state_nx = IDLE;
                  end else begin
                     state_nx = DWELL;
                     cnt_nx   = dwell_load;
                     wrap_nx  = wrap_pend_q;
                  end
               end else begin
                  cnt_nx = cnt_q - CNT_ONE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and internal counters.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wrap_pend_q <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_nx;
         cnt_q       <= cnt_nx;
         wrap_pend_q <= wrap_pend_nx;
         abort_q     <= abort_nx;
      end
   end

   // Registered outputs, decoded from the next state so they line up with it.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         x_q    <= 3'd0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         x_q    <= x_nx;
         en_q   <= (state_nx == DWELL);
         busy_q <= (state_nx != IDLE);
         wrap_q <= wrap_nx;
      end
   end

   assign bus.X    = x_q;
   assign bus.En   = en_q;
   assign bus.Busy = busy_q;
   assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer; mask scenario when SCAN_MASK_EN is defined
`timescale 1ns/1ps
module tb_scan_sequencer;
   localparam int DWELL_W   = 8;
   localparam int BLANK_CYC = 2;

   typedef struct packed {
      logic [2:0] x;
      logic       w;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst_n;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   exp_dwell = 1;
   exp_t sb[$];

   scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

   scan_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [2:0] x, input logic w);
      exp_t e;
      e.x = x;
      e.w = w;
      sb.push_back(e);
   endtask

   task automatic start_scan();
      bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   task automatic stop_scan(input logic [2:0] x_exp);
      bus.Stop = 1'b1;
      @(negedge Clk);
      bus.Stop = 1'b0;
      chk("stop_busy", bus.Busy, 0);
      chk("stop_en", bus.En, 0);
      chk("stop_x", bus.X, x_exp);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0) break;
         @(negedge Clk);
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   task automatic wait_en_x(input logic [2:0] xv, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if (bus.En && bus.X == xv) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_en_x", ok, 1);
   endtask

   // Monitor: pops the scoreboard on each DWELL entry, checks En run lengths and X quiet zones.
   logic       en_p   = 1'b0;
   logic       busy_p = 1'b0;
   logic [2:0] x_p    = 3'd0;
   int         hi_cnt = 0;
   int         lo_cnt = 0;
   always @(negedge Clk) begin
      exp_t e;
      if (bus.En && !en_p) begin
         chk("sb_pending", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dwell_x", bus.X, e.x);
            chk("dwell_wrap", bus.Wrap, e.w);
         end
         if (lo_cnt != 0) chk("blank_len", lo_cnt, BLANK_CYC);
         lo_cnt = 0;
      end else if (bus.Wrap !== 1'b0) begin
         chk("wrap_stray", bus.Wrap, 0);
      end
      if (!bus.En && en_p && bus.Busy) chk("dwell_len", hi_cnt, exp_dwell);
      if (bus.X !== x_p && busy_p && bus.Busy) chk("x_quiet_en", {en_p, bus.En}, 2'b00);
      hi_cnt = bus.En ? hi_cnt + 1 : 0;
      if (!bus.Busy) lo_cnt = 0;
      else if (!bus.En) lo_cnt = lo_cnt + 1;
      en_p   = bus.En;
      busy_p = bus.Busy;
      x_p    = bus.X;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst_n     = 1'b0;
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      bus.Dwell = 8'd3;
`ifdef SCAN_MASK_EN
      bus.Mask  = 8'h00;
`endif
      repeat (3) @(negedge Clk);
      chk("rst_x", bus.X, 0);
      chk("rst_en", bus.En, 0);
      chk("rst_busy", bus.Busy, 0);
      chk("rst_wrap", bus.Wrap, 0);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("idle_busy", bus.Busy, 0);
      chk("idle_en", bus.En, 0);

      // Full lap with Dwell=3, one wrap back to 0, stray Start mid-scan.
      exp_dwell = 3;
      bus.Dwell = 8'd3;
      for (int i = 0; i < 8; i++) push(3'(i), 1'b0);
      push(3'd0, 1'b1);
      start_scan();
      repeat (7) @(negedge Clk);
      start_scan();
      wait_drain(300);
      stop_scan(3'd0);

      // Dwell=0 behaves as one cycle.
      exp_dwell = 1;
      bus.Dwell = 8'd0;
      push(3'd0, 1'b0);
      push(3'd1, 1'b0);
      push(3'd2, 1'b0);
      start_scan();
      wait_drain(100);
      stop_scan(3'd2);

      // Stop on the second DWELL cycle of channel 4, then Start+Stop together.
      exp_dwell = 3;
      bus.Dwell = 8'd3;
      for (int i = 0; i < 5; i++) push(3'(i), 1'b0);
      start_scan();
      wait_en_x(3'd4, 200);
      @(negedge Clk);
      stop_scan(3'd4);
      chk("sb_after_stop", sb.size(), 0);
      bus.Start = 1'b1;
      bus.Stop  = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      repeat (2) @(negedge Clk);
      chk("startstop_busy", bus.Busy, 0);
      chk("startstop_en", bus.En, 0);
      chk("startstop_x", bus.X, 4);

      // Asynchronous reset in the middle of channel 5's dwell.
      for (int i = 0; i < 6; i++) push(3'(i), 1'b0);
      start_scan();
      wait_en_x(3'd5, 300);
      @(posedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      chk("arst_x", bus.X, 0);
      chk("arst_en", bus.En, 0);
      chk("arst_busy", bus.Busy, 0);
      chk("arst_wrap", bus.Wrap, 0);
      chk("sb_before_rst", sb.size(), 0);
      sb.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (6) @(negedge Clk);
      chk("post_rst_busy", bus.Busy, 0);
      chk("post_rst_en", bus.En, 0);
      chk("post_rst_x", bus.X, 0);

`ifdef SCAN_MASK_EN
      // Masked scan visits 1,3,4,6 and wraps back to 1; all-masked Start is ignored.
      exp_dwell = 1;
      bus.Dwell = 8'd1;
      bus.Mask  = 8'b1010_0101;
      push(3'd1, 1'b0);
      push(3'd3, 1'b0);
      push(3'd4, 1'b0);
      push(3'd6, 1'b0);
      push(3'd1, 1'b1);
      start_scan();
      wait_drain(200);
      stop_scan(3'd1);
      bus.Mask = 8'hFF;
      start_scan();
      repeat (3) @(negedge Clk);
      chk("mask_ff_busy", bus.Busy, 0);
      chk("mask_ff_x", bus.X, 1);
      bus.Mask = 8'h00;
`endif

      repeat (4) @(negedge Clk);
      chk("sb_final", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of Dwell input.
REQ-002 SHALL have parameter BLANK_CYC, default 2, En-low cycles between channels; values below 2 SHALL behave as 2.
REQ-003 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  begin scan, sampled in IDLE only.
REQ-006 SHALL have port Stop  input  1  abort scan, sampled every cycle.
REQ-007 SHALL have port Dwell  input  DWELL_W  En-high cycles per channel.
REQ-008 SHALL have port Mask  input  8  per-channel skip bits (present only under SCAN_MASK_EN).
REQ-009 SHALL have port X  output  3  channel index to 3-to-8 decoder, registered.
REQ-010 SHALL have port En  output  1  decoder enable, registered.
REQ-011 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port Wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 SHALL implement states IDLE, DWELL, BLANK; all outputs SHALL be registered.
REQ-014 IDLE: En=0, Busy=0, X holds last value; Start=1 and Stop=0 SHALL enter DWELL next cycle with X = first channel.
REQ-015 DWELL: En=1 for exactly max(Dwell,1) cycles, Dwell sampled at DWELL entry; then enter BLANK.
REQ-016 BLANK: En=0 for exactly BLANK_CYC cycles, then DWELL with next channel.
REQ-017 X SHALL change only on the clock edge ending the first BLANK cycle, so X never changes in a cycle adjacent to an En edge.
REQ-018 Next channel SHALL be (X+1) mod 8; index 7 SHALL wrap to 0.
REQ-019 Wrap SHALL be high for one cycle, concurrent with the first DWELL cycle of a channel whose index is less than or equal to the previous channel's; it SHALL NOT pulse on the initial entry from IDLE.
REQ-020 Stop=1 in DWELL or BLANK SHALL enter IDLE next cycle with En=0; X SHALL hold.
REQ-021 Stop and Start asserted together in IDLE: Stop SHALL win and the block SHALL remain in IDLE.
REQ-022 Start in DWELL or BLANK SHALL be ignored.
REQ-023 En SHALL never be high in two different channels without at least BLANK_CYC En-low cycles between them.

Reset
REQ-024 Rst_n=0 SHALL immediately force IDLE, X=0, En=0, Busy=0, Wrap=0, and clear internal counters, regardless of Clk.
REQ-025 Reset asserted mid-DWELL SHALL drop En within the same cycle; deassertion is synchronised externally.
REQ-026 After reset release, the block SHALL wait in IDLE for Start.

Configuration
REQ-027 Macro SCAN_MASK_EN SHALL, when defined, add port Mask; channels with Mask[i]=1 SHALL be skipped.
REQ-028 With SCAN_MASK_EN, first channel SHALL be the lowest unmasked index and next channel SHALL be the next unmasked index in increasing order, modulo 8.
REQ-029 With SCAN_MASK_EN, Mask SHALL be sampled in IDLE at Start and in the first BLANK cycle.
REQ-030 With SCAN_MASK_EN, Mask=8'hFF SHALL cause Start to be ignored, and SHALL cause entry to IDLE at the end of the current BLANK.
REQ-031 Without SCAN_MASK_EN, Mask SHALL not exist and all 8 channels SHALL be visited in order.

Verification
REQ-032 Dwell=3, BLANK_CYC=2, Start pulse -> En pattern 1,1,1,0,0 repeating; X sequence 0..7,0; Wrap once at second X=0 entry.
REQ-033 Dwell=0 -> En high exactly 1 cycle per channel.
REQ-034 Stop at second DWELL cycle of X=4 -> En=0 and Busy=0 next cycle, X=4 held; Start+Stop same cycle -> stays IDLE.
REQ-035 Rst_n pulled low mid-DWELL of X=5 -> X=0, En=0 asynchronously; no activity until next Start.
REQ-036 SCAN_MASK_EN, Mask=8'b1010_0101 -> X sequence 1,3,4,6,1; Wrap at return to 1; Mask=8'hFF at Start -> Busy stays 0.
REQ-037 All scenarios: checker confirms X never changes within one cycle of an En edge.
